// File: rtl/jesd_seq_pkg.sv
// Shared definitions for the JESD link bring-up sequencer: the state
// encoding reported on the state port and helpers for sizing the timers.
package jesd_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_RST_ASSERT  = 4'd1,
        ST_RST_SETTLE  = 4'd2,
        ST_HMC_SYNC    = 4'd3,
        ST_SYSREF_WAIT = 4'd4,
        ST_LINK_WAIT   = 4'd5,
        ST_RUN         = 4'd6,
        ST_FAIL        = 4'd7
    } seq_state_e;

    // Larger of two durations, used to size one shared timer.
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold any count from 0 up to max_count inclusive.
    function automatic int timer_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // A duration of N cycles is counted as N-1 down to 0; zero-length
    // durations are treated as one cycle so the load never underflows.
    function automatic int load_value(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/jesd_link_sequencer_timer.sv
// Loadable down-counter used for every fixed duration and timeout of the
// sequencer. It parks at zero and flags expiry while the count is zero.
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Reload on state entry, otherwise count down and hold at zero (no wrap).
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/jesd_link_sequencer.sv
// JESD link bring-up sequencer: converter reset, settle, clock-chip sync,
// SYSREF capture and link-up wait, with bounded retries.
// Optional feature: define SEQ_WATCHDOG_EN to restart the bring-up when a
// link drops while running (counted in lost_cnt).
module jesd_link_sequencer
    import jesd_seq_pkg::*;
#(
    parameter int NUM_LINKS         = 1,
    parameter int RST_HOLD_CYCLES   = 1024,
    parameter int SETTLE_CYCLES     = 4096,
    parameter int SYNC_PULSE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 1000000,
    parameter int MAX_RETRIES       = 3
) (
    input  logic                 axil_aclk,
    input  logic                 axil_aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sysref_seen,
    input  logic [NUM_LINKS-1:0] link_up,
    output logic                 rstb,
    output logic                 hmc_sync,
    output logic                 link_en,
    output logic [1:0]           rxen,
    output logic [1:0]           txen,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [3:0]           state,
    output logic [3:0]           retry_cnt,
    output logic [7:0]           lost_cnt
);

    localparam int MAX_DUR = max_of(max_of(RST_HOLD_CYCLES, SETTLE_CYCLES),
                                    max_of(SYNC_PULSE_CYCLES, TIMEOUT_CYCLES));
    localparam int TW = timer_width(MAX_DUR);

    localparam logic [TW-1:0] HOLD_LD    = TW'(load_value(RST_HOLD_CYCLES));
    localparam logic [TW-1:0] SETTLE_LD  = TW'(load_value(SETTLE_CYCLES));
    localparam logic [TW-1:0] SYNC_LD    = TW'(load_value(SYNC_PULSE_CYCLES));
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(load_value(TIMEOUT_CYCLES));

    seq_state_e state_q;
    seq_state_e state_d;
    logic [3:0] retry_q;
    logic [3:0] retry_d;
    logic [7:0] lost_q;
    logic [7:0] lost_d;
    logic       timeout_hit;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

    logic       rstb_q;
    logic       hmc_sync_q;
    logic       link_en_q;
    logic [1:0] rxen_q;
    logic [1:0] txen_q;
    logic       busy_q;
    logic       done_q;
    logic       fail_q;

    seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i      (axil_aclk),
        .rst_ni     (axil_aresetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Next state and counters; abort overrides everything, timeouts retry
    // until the budget is spent and then park in FAIL.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lost_d      = lost_q;
        timeout_hit = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_FAIL: begin
                    if (start) begin
                        state_d = ST_RST_ASSERT;
                        retry_d = 4'd0;
                    end
                end
                ST_RST_ASSERT: begin
                    if (tmr_expired) state_d = ST_RST_SETTLE;
                end
                ST_RST_SETTLE: begin
                    if (tmr_expired) state_d = ST_HMC_SYNC;
                end
                ST_HMC_SYNC: begin
                    if (tmr_expired) state_d = ST_SYSREF_WAIT;
                end
                ST_SYSREF_WAIT: begin
                    if (sysref_seen) begin
                        state_d = ST_LINK_WAIT;
                    end else if (tmr_expired) begin
                        timeout_hit = 1'b1;
                    end
                end
                ST_LINK_WAIT: begin
                    if (&link_up) begin
                        state_d = ST_RUN;
                    end else if (tmr_expired) begin
                        timeout_hit = 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef SEQ_WATCHDOG_EN
                    if (!(&link_up)) begin
                        state_d = ST_RST_ASSERT;
                        retry_d = 4'd0;
                        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
            if (timeout_hit) begin
                if (int'(retry_q) < MAX_RETRIES) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ST_RST_ASSERT;
                end else begin
                    state_d = ST_FAIL;
                end
            end
        end
    end

    // Timer is loaded with the duration of the state being entered.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        unique case (state_d)
            ST_RST_ASSERT:  tmr_val = HOLD_LD;
            ST_RST_SETTLE:  tmr_val = SETTLE_LD;
            ST_HMC_SYNC:    tmr_val = SYNC_LD;
            ST_SYSREF_WAIT: tmr_val = TIMEOUT_LD;
            ST_LINK_WAIT:   tmr_val = TIMEOUT_LD;
            default:        tmr_val = '0;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state_q <= ST_IDLE;
            retry_q <= 4'd0;
            lost_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
        end
    end

    // Outputs decoded from the next state so they change with the state.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            rstb_q     <= 1'b0;
            hmc_sync_q <= 1'b0;
            link_en_q  <= 1'b0;
            rxen_q     <= 2'b00;
            txen_q     <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            rstb_q     <= !(state_d inside {ST_IDLE, ST_RST_ASSERT});
            hmc_sync_q <= (state_d == ST_HMC_SYNC);
            link_en_q  <= (state_d inside {ST_LINK_WAIT, ST_RUN});
            rxen_q     <= {2{state_d inside {ST_LINK_WAIT, ST_RUN}}};
            txen_q     <= {2{state_d inside {ST_LINK_WAIT, ST_RUN}}};
            busy_q     <= !(state_d inside {ST_IDLE, ST_RUN, ST_FAIL});
            done_q     <= (state_d == ST_RUN);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

    assign rstb      = rstb_q;
    assign hmc_sync  = hmc_sync_q;
    assign link_en   = link_en_q;
    assign rxen      = rxen_q;
    assign txen      = txen_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_jesd_link_sequencer.sv
// Testbench for jesd_link_sequencer. Expected behaviour comes from a
// timeline model that lays out each bring-up attempt with plain arithmetic
// over the stimulus arrays.
module tb_jesd_link_sequencer;
    import jesd_seq_pkg::*;

    localparam int NL   = 2;
    localparam int H    = 4;
    localparam int S    = 8;
    localparam int P    = 2;
    localparam int T    = 100;
    localparam int MR   = 2;
    localparam int MAXC = 400;

    logic          axil_aclk = 1'b0;
    logic          axil_aresetn;
    logic          start;
    logic          abort;
    logic          sysref_seen;
    logic [NL-1:0] link_up;
    logic          rstb;
    logic          hmc_sync;
    logic          link_en;
    logic [1:0]    rxen;
    logic [1:0]    txen;
    logic          busy;
    logic          done;
    logic          fail;
    logic [3:0]    state;
    logic [3:0]    retry_cnt;
    logic [7:0]    lost_cnt;

    int nCmp  = 0;
    int nFail = 0;

    bit         startS  [MAXC];
    bit         abortS  [MAXC];
    bit         sysrefS [MAXC];
    logic [1:0] luS     [MAXC];
    logic [3:0] expSt   [MAXC];
    logic [3:0] expRt   [MAXC];
    logic [7:0] expLo   [MAXC];

    jesd_link_sequencer #(
        .NUM_LINKS         (NL),
        .RST_HOLD_CYCLES   (H),
        .SETTLE_CYCLES     (S),
        .SYNC_PULSE_CYCLES (P),
        .TIMEOUT_CYCLES    (T),
        .MAX_RETRIES       (MR)
    ) dut (
        .axil_aclk    (axil_aclk),
        .axil_aresetn (axil_aresetn),
        .start        (start),
        .abort        (abort),
        .sysref_seen  (sysref_seen),
        .link_up      (link_up),
        .rstb         (rstb),
        .hmc_sync     (hmc_sync),
        .link_en      (link_en),
        .rxen         (rxen),
        .txen         (txen),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lost_cnt     (lost_cnt)
    );

    // Free-running 10-time-unit clock.
    always #5 axil_aclk = ~axil_aclk;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [25:0] actVec();
        return {state, retry_cnt, lost_cnt, rstb, hmc_sync, link_en, rxen, txen, busy, done, fail};
    endfunction

    // Output values implied by a state, per the bring-up rules.
    function automatic logic [25:0] expVec(input int c);
        logic [3:0] st;
        logic en;
        st = expSt[c];
        en = (st == ST_LINK_WAIT) || (st == ST_RUN);
        return {st, expRt[c], expLo[c],
                !((st == ST_IDLE) || (st == ST_RST_ASSERT)),
                (st == ST_HMC_SYNC), en, {2{en}}, {2{en}},
                !((st == ST_IDLE) || (st == ST_RUN) || (st == ST_FAIL)),
                (st == ST_RUN), (st == ST_FAIL)};
    endfunction

    function automatic void fill(input int from, input int len, input logic [3:0] st,
                                 input logic [3:0] rt, input logic [7:0] lo);
        for (int k = from; k < from + len && k < MAXC; k++) begin
            expSt[k] = st;
            expRt[k] = rt;
            expLo[k] = lo;
        end
    endfunction

    function automatic int firstSysref(input int c);
        for (int k = c; k < c + T && k < MAXC; k++) if (sysrefS[k]) return k;
        return -1;
    endfunction

    function automatic int firstAllUp(input int c);
        for (int k = c; k < c + T && k < MAXC; k++) if (luS[k] == 2'b11) return k;
        return -1;
    endfunction

    function automatic int firstDrop(input int c);
        for (int k = c; k < MAXC; k++) if (luS[k] != 2'b11) return k;
        return -1;
    endfunction

    // Timeline model: state seen during each cycle, given one start at
    // startC and an optional abort at abortC (-1 for none).
    function automatic void buildModel(input logic [3:0] preSt, input logic [3:0] preRt,
                                       input logic [7:0] preLo, input int startC, input int abortC);
        int c;
        int k;
        int retries;
        int lost;
        bit timedOut;
        fill(0, startC + 1, preSt, preRt, preLo);
        c = startC + 1;
        retries = 0;
        lost = int'(preLo);
        while (c < MAXC) begin
            timedOut = 1'b0;
            fill(c, H, ST_RST_ASSERT, 4'(retries), 8'(lost)); c += H;
            fill(c, S, ST_RST_SETTLE, 4'(retries), 8'(lost)); c += S;
            fill(c, P, ST_HMC_SYNC,   4'(retries), 8'(lost)); c += P;
            k = firstSysref(c);
            if (k < 0) begin
                fill(c, T, ST_SYSREF_WAIT, 4'(retries), 8'(lost)); c += T;
                timedOut = 1'b1;
            end else begin
                fill(c, k - c + 1, ST_SYSREF_WAIT, 4'(retries), 8'(lost)); c = k + 1;
                k = firstAllUp(c);
                if (k < 0) begin
                    fill(c, T, ST_LINK_WAIT, 4'(retries), 8'(lost)); c += T;
                    timedOut = 1'b1;
                end else begin
                    fill(c, k - c + 1, ST_LINK_WAIT, 4'(retries), 8'(lost)); c = k + 1;
`ifdef SEQ_WATCHDOG_EN
                    k = firstDrop(c);
                    if (k < 0) begin
                        fill(c, MAXC - c, ST_RUN, 4'(retries), 8'(lost)); c = MAXC;
                    end else begin
                        fill(c, k - c + 1, ST_RUN, 4'(retries), 8'(lost)); c = k + 1;
                        if (lost < 255) lost++;
                        retries = 0;
                    end
`else
                    fill(c, MAXC - c, ST_RUN, 4'(retries), 8'(lost)); c = MAXC;
`endif
                end
            end
            if (timedOut && c < MAXC) begin
                if (retries < MR) retries++;
                else begin
                    fill(c, MAXC - c, ST_FAIL, 4'(retries), 8'(lost)); c = MAXC;
                end
            end
        end
        if (abortC > startC) begin
            for (int j = abortC + 1; j < MAXC; j++) begin
                expSt[j] = ST_IDLE;
                expRt[j] = expRt[abortC];
                expLo[j] = expLo[abortC];
            end
        end
    endfunction

    task automatic clearStim();
        for (int k = 0; k < MAXC; k++) begin
            startS[k] = 1'b0; abortS[k] = 1'b0; sysrefS[k] = 1'b0; luS[k] = 2'b00;
        end
    endtask

    task automatic driveCycle(input int c);
        start       = startS[c];
        abort       = abortS[c];
        sysref_seen = sysrefS[c];
        link_up     = luS[c];
    endtask

    task automatic doReset();
        axil_aresetn = 1'b0;
        start = 1'b0; abort = 1'b0; sysref_seen = 1'b0; link_up = '0;
        repeat (2) @(posedge axil_aclk);
        @(negedge axil_aclk);
        axil_aresetn = 1'b1;
        @(posedge axil_aclk);
        #1;
    endtask

    // Standard bring-up stimulus: start at 0, SYSREF at 20, links up at 40.
    task automatic nominalStim();
        clearStim();
        startS[0] = 1'b1;
        for (int k = 20; k < MAXC; k++) sysrefS[k] = 1'b1;
        for (int k = 40; k < MAXC; k++) luS[k] = 2'b11;
    endtask

    task automatic test_reset();
        axil_aresetn = 1'b0;
        start = 1'b0; abort = 1'b0; sysref_seen = 1'b0; link_up = '0;
        #3;
        nCmp++;
        if (actVec() !== 26'd0) begin
            nFail++;
            $display("[TB] FAIL reset_state: got %h want %h", actVec(), 26'd0);
        end
        doReset();
    endtask

    task automatic test_nominal();
        doReset();
        nominalStim();
        buildModel(ST_IDLE, 4'd0, 8'd0, 0, -1);
        for (int c = 0; c < 60; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL nominal cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            if (c >= 1 && c <= 4) begin
                nCmp++;
                if (rstb !== 1'b0) begin nFail++; $display("[TB] FAIL nominal_rstb cyc %0d: got %b want 0", c, rstb); end
            end
            if (c == 13 || c == 14) begin
                nCmp++;
                if (hmc_sync !== 1'b1) begin nFail++; $display("[TB] FAIL nominal_sync cyc %0d: got %b want 1", c, hmc_sync); end
            end
            if (c == 41) begin
                nCmp++;
                if (done !== 1'b1 || state !== 4'd6) begin
                    nFail++; $display("[TB] FAIL nominal_run cyc 41: got done=%b state=%0d want 1/6", done, state);
                end
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
    endtask

    task automatic test_retry_exhaust();
        doReset();
        clearStim();
        startS[0] = 1'b1;
        buildModel(ST_IDLE, 4'd0, 8'd0, 0, -1);
        for (int c = 0; c < 380; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL retry cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            if (c == 115 || c == 229 || c == 343) begin
                nCmp++;
                if (retry_cnt !== ((c == 115) ? 4'd1 : 4'd2) ||
                    state !== ((c == 343) ? 4'd7 : 4'd1)) begin
                    nFail++;
                    $display("[TB] FAIL retry_points cyc %0d: got retry=%0d state=%0d", c, retry_cnt, state);
                end
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
        // A fresh start out of FAIL restarts with the retry count cleared.
        nominalStim();
        buildModel(ST_FAIL, 4'd2, 8'd0, 0, -1);
        for (int c = 0; c < 50; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL restart cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            if (c == 1) begin
                nCmp++;
                if (retry_cnt !== 4'd0 || fail !== 1'b0) begin
                    nFail++; $display("[TB] FAIL restart_clear: got retry=%0d fail=%b want 0/0", retry_cnt, fail);
                end
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
    endtask

    task automatic test_partial_link();
        doReset();
        nominalStim();
        for (int k = 0; k < MAXC; k++) luS[k] = 2'b01;
        buildModel(ST_IDLE, 4'd0, 8'd0, 0, -1);
        for (int c = 0; c < 130; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL partial cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            if (c == 121) begin
                nCmp++;
                if (state !== 4'd1 || retry_cnt !== 4'd1 || rstb !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL partial_timeout: got state=%0d retry=%0d rstb=%b want 1/1/0", state, retry_cnt, rstb);
                end
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
    endtask

    task automatic test_abort_priority();
        doReset();
        nominalStim();
        startS[13] = 1'b1;
        abortS[13] = 1'b1;
        buildModel(ST_IDLE, 4'd0, 8'd0, 0, 13);
        for (int c = 0; c < 30; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL abort cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            if (c == 14) begin
                nCmp++;
                if (state !== 4'd0 || hmc_sync !== 1'b0 || busy !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL abort_idle: got state=%0d hmc_sync=%b busy=%b want 0/0/0", state, hmc_sync, busy);
                end
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
    endtask

    task automatic test_watchdog();
        doReset();
        nominalStim();
        luS[50] = 2'b01;
        buildModel(ST_IDLE, 4'd0, 8'd0, 0, -1);
        for (int c = 0; c < 90; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL watchdog cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            if (c == 51) begin
                nCmp++;
`ifdef SEQ_WATCHDOG_EN
                if (state !== 4'd1 || lost_cnt !== 8'd1) begin
                    nFail++; $display("[TB] FAIL watchdog_drop: got state=%0d lost=%0d want 1/1", state, lost_cnt);
                end
`else
                if (state !== 4'd6 || lost_cnt !== 8'd0) begin
                    nFail++; $display("[TB] FAIL watchdog_drop: got state=%0d lost=%0d want 6/0", state, lost_cnt);
                end
`endif
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        clearStim();
        startS[0] = 1'b1;
        buildModel(ST_IDLE, 4'd0, 8'd0, 0, -1);
        for (int c = 0; c < 20; c++) begin
            nCmp++;
            if (actVec() !== expVec(c)) begin
                nFail++;
                $display("[TB] FAIL reset_mid cyc %0d: got %h want %h", c, actVec(), expVec(c));
            end
            driveCycle(c);
            @(posedge axil_aclk); #1;
        end
        #2;
        axil_aresetn = 1'b0;
        #1;
        nCmp++;
        if (actVec() !== 26'd0) begin
            nFail++;
            $display("[TB] FAIL reset_async: got %h want %h", actVec(), 26'd0);
        end
        @(posedge axil_aclk); #1;
        nCmp++;
        if (actVec() !== 26'd0) begin
            nFail++;
            $display("[TB] FAIL reset_hold: got %h want %h", actVec(), 26'd0);
        end
        axil_aresetn = 1'b1;
    endtask

    task automatic test_random();
        int st;
        int lt;
        int ab;
        for (int it = 0; it < 5; it++) begin
            doReset();
            clearStim();
            st = int'($urandom_range(15, 140));
            lt = st + int'($urandom_range(1, 120));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 300)) : -1;
            startS[0] = 1'b1;
            startS[5] = 1'b1;
            for (int k = st; k < MAXC; k++) sysrefS[k] = 1'b1;
            for (int k = 0; k < MAXC; k++) luS[k] = (k < lt) ? 2'($urandom_range(0, 3)) : 2'b11;
            if (ab >= 0) abortS[ab] = 1'b1;
            buildModel(ST_IDLE, 4'd0, 8'd0, 0, ab);
            for (int c = 0; c < MAXC; c++) begin
                nCmp++;
                if (actVec() !== expVec(c)) begin
                    nFail++;
                    $display("[TB] FAIL random it%0d cyc %0d (sysref=%0d link=%0d abort=%0d): got %h want %h",
                             it, c, st, lt, ab, actVec(), expVec(c));
                end
                driveCycle(c);
                @(posedge axil_aclk); #1;
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_nominal();
        test_retry_exhaust();
        test_partial_link();
        test_abort_priority();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/jesd_link_sequencer.md
JESD_LINK_SEQUENCER -- requirements
Module: jesd_link_sequencer

Interface
REQ-001 SHALL have parameter NUM_LINKS, default 1: number of JESD links monitored.
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 1024: converter reset (rstb low) duration.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4096: wait after rstb release before clock sync.
REQ-004 SHALL have parameter SYNC_PULSE_CYCLES, default 16: hmc_sync high duration.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum wait for sysref or link-up.
REQ-006 SHALL have parameter MAX_RETRIES, default 3: bring-up retries before FAIL.
REQ-007 SHALL have port axil_aclk, input, 1: the only clock.
REQ-008 SHALL have port axil_aresetn, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port start, input, 1: single-cycle bring-up request.
REQ-010 SHALL have port abort, input, 1: single-cycle cancel request.
REQ-011 SHALL have port sysref_seen, input, 1: level, high once SYSREF is captured.
REQ-012 SHALL have port link_up, input, NUM_LINKS: per-link DATA-phase status.
REQ-013 SHALL have ports rstb, hmc_sync, link_en, each output, 1: converter reset (active-low), clock-chip sync, JESD core enable.
REQ-014 SHALL have ports rxen and txen, each output, 2: converter datapath enables.
REQ-015 SHALL have ports busy, done, fail, each output, 1; state, output, 4; retry_cnt, output, 4; lost_cnt, output, 8.

Function
REQ-016 SHALL implement states IDLE, RST_ASSERT, RST_SETTLE, HMC_SYNC, SYSREF_WAIT, LINK_WAIT, RUN, FAIL, with state reporting the encoding from the package.
REQ-017 SHALL act on start only in IDLE or FAIL: next cycle enter RST_ASSERT and clear retry_cnt; start in any other state SHALL be ignored.
REQ-018 SHALL hold rstb=0 for exactly RST_HOLD_CYCLES cycles in RST_ASSERT, then enter RST_SETTLE with rstb=1.
REQ-019 SHALL stay SETTLE_CYCLES cycles in RST_SETTLE, then enter HMC_SYNC.
REQ-020 SHALL drive hmc_sync=1 for exactly SYNC_PULSE_CYCLES cycles in HMC_SYNC, then enter SYSREF_WAIT.
REQ-021 SHALL leave SYSREF_WAIT for LINK_WAIT on the first cycle sysref_seen=1; if TIMEOUT_CYCLES cycles elapse first, this is a timeout.
REQ-022 SHALL drive link_en=1 and rxen=txen=2'b11 in LINK_WAIT and RUN, and 0 elsewhere.
REQ-023 SHALL enter RUN when all link_up bits are 1 in the same cycle; otherwise a timeout occurs after TIMEOUT_CYCLES cycles.
REQ-024 On timeout SHALL increment retry_cnt and re-enter RST_ASSERT if retry_cnt < MAX_RETRIES, otherwise enter FAIL with retry_cnt unchanged.
REQ-025 SHALL let abort take priority over start and timeouts: in any non-IDLE state, next cycle is IDLE with all outputs at reset values except retry_cnt and lost_cnt, which hold.
REQ-026 SHALL assert busy in every state except IDLE, RUN and FAIL, done only in RUN, and fail only in FAIL.
REQ-027 SHALL register all outputs; state-dependent outputs change on the cycle the state changes.
REQ-028 SHALL use timer counters wide enough for the largest parameter, loaded on state entry; every counted duration is exact and has no wrap.

Reset
REQ-029 SHALL on axil_aresetn=0, asynchronously: state=IDLE, rstb=0, hmc_sync=0, link_en=0, rxen=0, txen=0, busy=0, done=0, fail=0, retry_cnt=0, lost_cnt=0, timers=0; a reset mid-sequence SHALL abandon the sequence.

Configuration
REQ-030 SHALL, when SEQ_WATCHDOG_EN is defined: in RUN, any link_up bit low for one cycle increments lost_cnt (saturating at 255), clears retry_cnt, and re-enters RST_ASSERT next cycle.
REQ-031 SHALL, when SEQ_WATCHDOG_EN is undefined: RUN is left only by abort or reset, link_up is ignored in RUN, and lost_cnt is constant 0.

Structure
REQ-032 SHALL take the state enum, its 4-bit encoding and the timer width function from the shared package jesd_seq_pkg.
REQ-033 SHALL build the duration and timeout counting in one sub-module, seq_timer: a loadable down-counter with an expire flag.

Verification (RST_HOLD=4, SETTLE=8, SYNC_PULSE=2, TIMEOUT=100, MAX_RETRIES=2, NUM_LINKS=2)
REQ-034 SHALL cover the nominal path: start at cycle 0; sysref_seen at 20; link_up=2'b11 at 40 -> rstb low cycles 1-4; hmc_sync high cycles 13-14; RUN by cycle 41; done=1.
REQ-035 SHALL cover retry exhaustion: sysref_seen never asserted -> two retries (retry_cnt 1, then 2), then FAIL, fail=1, retry_cnt=2; a later start restarts with retry_cnt=0.
REQ-036 SHALL cover partial link: link_up=2'b01 throughout LINK_WAIT -> timeout after 100 cycles, retry_cnt=1, rstb=0 next cycle.
REQ-037 SHALL cover abort priority: start and abort in the same cycle during HMC_SYNC -> IDLE next cycle, hmc_sync=0, busy=0.
REQ-038 SHALL cover the watchdog under SEQ_WATCHDOG_EN: in RUN drop link_up[1] for 1 cycle -> lost_cnt=1, RST_ASSERT next cycle; without the macro -> stays in RUN, lost_cnt=0.
REQ-039 SHALL cover reset mid-sequence: axil_aresetn low during SYSREF_WAIT -> all outputs at reset values immediately, without waiting for a clock edge.
